btn_conditioner: RTL and testbench

- Conditions the 5 raw board push-buttons ({BTNC, BTNU, BTND, BTNL, BTNR}) before they reach the digital_clock user logic's btn input.
- Per button it provides:
  - a 2-flop synchroniser;
  - a counter-based debouncer;
  - single-cycle press and release pulses;
  - long-press detection with auto-repeat press pulses, used for fast time-setting.
- It is instantiated in the top userspace between BTN and the user module. It runs on the 100 MHz board clock.

---
 rtl/btn_conditioner.sv | 167 ++++++++++++++++
 tb/tb_btn_conditioner.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Push-button conditioner: per-button 2-flop synchroniser, counter-based debouncer,
// single-cycle press/release pulses and long-press detection with optional auto-repeat.
//
// Ports:
//   clk_i          board clock, all logic on the rising edge
//   rst_ni         asynchronous active-low reset
//   btn_raw_i      raw asynchronous button levels, active high
//   btn_level_o    debounced button level
//   btn_press_o    1-cycle pulse on accepted press and on each auto-repeat
//   btn_release_o  1-cycle pulse on accepted release
//   btn_long_o     high while the button is in long-press
module btn_conditioner #(
  parameter int unsigned N               = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] btn_raw_i,
  output logic [N-1:0] btn_level_o,
  output logic [N-1:0] btn_press_o,
  output logic [N-1:0] btn_release_o,
  output logic [N-1:0] btn_long_o
);

  localparam int unsigned MaxDh     = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES
                                                                      : HOLD_CYCLES;
  localparam int unsigned MaxCycles = (MaxDh > REPEAT_CYCLES) ? MaxDh : REPEAT_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 2) ? $clog2(MaxCycles) : 1;

  // Terminal counts: each counting state compares before incrementing, so the
  // counter only ever needs to reach <param>-1 and never wraps.
  localparam logic [CntW-1:0] DebLast  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] RepLast  = CntW'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StPressed,
    StHeld,
    StDisarm
  } state_e;

  logic [N-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_btn
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            long_q, long_d;
    logic            s;

    assign s = sync2_q[i];

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      long_d    = long_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
        StIdle: begin
          if (s) begin
            state_d = StArm;
            cnt_d   = '0;
          end
        end
        StArm: begin
          if (!s) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_q == DebLast) begin
            state_d = StPressed;
            cnt_d   = '0;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StPressed: begin
          if (!s) begin
            state_d = StDisarm;
            cnt_d   = '0;
          end else if (cnt_q == HoldLast) begin
            state_d = StHeld;
            cnt_d   = '0;
            long_d  = 1'b1;
            press_d = REPEAT_EN;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StHeld: begin
          if (!s) begin
            state_d = StDisarm;
            cnt_d   = '0;
          end else if (cnt_q == RepLast) begin
            cnt_d   = '0;
            press_d = REPEAT_EN;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StDisarm: begin
          // Level stays 1 here; a bounce back restarts the hold/repeat timer.
          if (s) begin
            state_d = long_q ? StHeld : StPressed;
            cnt_d   = '0;
          end else if (cnt_q == DebLast) begin
            state_d   = StIdle;
            cnt_d     = '0;
            level_d   = 1'b0;
            long_d    = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q   <= StIdle;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
      end
    end

    assign btn_level_o[i]   = level_q;
    assign btn_press_o[i]   = press_q;
    assign btn_release_o[i] = release_q;
    assign btn_long_o[i]    = long_q;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner with short timing parameters
// (DEBOUNCE=4, HOLD=20, REPEAT=8). Expected pulses are queued as ids
// (button*1000 + edge number) when stimulus is applied and popped as the DUT emits them.
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [4:0] raw;
  logic [4:0] level, press, rel, lng;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_press[$];
  int exp_rel[$];

  always #5 clk = ~clk;

  btn_conditioner #(
    .N              (5),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (20),
    .REPEAT_CYCLES  (8),
    .REPEAT_EN      (1'b1)
  ) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .btn_raw_i    (raw),
    .btn_level_o  (level),
    .btn_press_o  (press),
    .btn_release_o(rel),
    .btn_long_o   (lng)
  );

  task automatic test_reset();
    rst_ni = 1'b0;
    raw    = 5'b11111;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (level !== 5'b0) begin n_fail++; $display("FAIL reset level: got %b want 00000", level); end
    n_checks++;
    if (press !== 5'b0) begin n_fail++; $display("FAIL reset press: got %b want 00000", press); end
    n_checks++;
    if (rel !== 5'b0) begin n_fail++; $display("FAIL reset release: got %b want 00000", rel); end
    n_checks++;
    if (lng !== 5'b0) begin n_fail++; $display("FAIL reset long: got %b want 00000", lng); end
    raw    = 5'b0;
    rst_ni = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (level !== 5'b0) begin n_fail++; $display("FAIL idle level: got %b want 00000", level); end
  endtask

  // 40-cycle hold outlasts HOLD_CYCLES, so long-press pulses appear at 27 and 35 too.
  task automatic test_clean_press();
    int want;
    exp_press = {7, 27, 35};
    exp_rel   = {47};
    @(posedge clk); #1;
    raw[0] = 1'b1;
    for (int k = 1; k <= 55; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
        if (press[i]) begin
          n_checks++;
          want = -1;
          if (exp_press.size() > 0) want = exp_press.pop_front();
          if (i * 1000 + k !== want) begin
            n_fail++;
            $display("FAIL clean press: got id %0d want id %0d", i * 1000 + k, want);
          end
        end
        if (rel[i]) begin
          n_checks++;
          want = -1;
          if (exp_rel.size() > 0) want = exp_rel.pop_front();
          if (i * 1000 + k !== want) begin
            n_fail++;
            $display("FAIL clean release: got id %0d want id %0d", i * 1000 + k, want);
          end
        end
      end
      if (k == 6 || k == 7 || k == 46 || k == 47) begin
        n_checks++;
        if (level[0] !== (k == 7 || k == 46)) begin
          n_fail++;
          $display("FAIL clean level@%0d: got %b want %b", k, level[0], (k == 7 || k == 46));
        end
      end
      if (k == 40) raw[0] = 1'b0;
    end
    n_checks++;
    if (exp_press.size() + exp_rel.size() != 0) begin
      n_fail++;
      $display("FAIL clean missing: %0d press %0d release pulses not seen",
               exp_press.size(), exp_rel.size());
    end
  endtask

  // Pulses of 3 and 4 cycles are rejected; 5 cycles is the shortest accepted.
  task automatic test_glitch();
    int want;
    int lens[3] = '{3, 4, 5};
    logic seen;
    for (int n = 0; n < 3; n++) begin
      exp_press = {};
      exp_rel   = {};
      if (lens[n] == 5) begin
        exp_press.push_back(1007);
        exp_rel.push_back(1012);
      end
      seen = 1'b0;
      @(posedge clk); #1;
      raw[1] = 1'b1;
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk); #1;
        seen = seen | level[1] | lng[1];
        for (int i = 0; i < 5; i++) begin
          if (press[i]) begin
            n_checks++;
            want = -1;
            if (exp_press.size() > 0) want = exp_press.pop_front();
            if (i * 1000 + k !== want) begin
              n_fail++;
              $display("FAIL glitch%0d press: got id %0d want id %0d", lens[n], i * 1000 + k,
                       want);
            end
          end
          if (rel[i]) begin
            n_checks++;
            want = -1;
            if (exp_rel.size() > 0) want = exp_rel.pop_front();
            if (i * 1000 + k !== want) begin
              n_fail++;
              $display("FAIL glitch%0d release: got id %0d want id %0d", lens[n], i * 1000 + k,
                       want);
            end
          end
        end
        if (k == lens[n]) raw[1] = 1'b0;
      end
      n_checks++;
      if (seen !== (lens[n] == 5)) begin
        n_fail++;
        $display("FAIL glitch%0d level seen: got %b want %b", lens[n], seen, (lens[n] == 5));
      end
      n_checks++;
      if (exp_press.size() + exp_rel.size() != 0) begin
        n_fail++;
        $display("FAIL glitch%0d missing pulses", lens[n]);
      end
    end
  endtask

  task automatic test_long_repeat();
    int want;
    exp_press = {2007, 2027, 2035, 2043, 2051, 2059, 2067};
    exp_rel   = {2077};
    @(posedge clk); #1;
    raw[2] = 1'b1;
    for (int k = 1; k <= 85; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
        if (press[i]) begin
          n_checks++;
          want = -1;
          if (exp_press.size() > 0) want = exp_press.pop_front();
          if (i * 1000 + k !== want) begin
            n_fail++;
            $display("FAIL long press: got id %0d want id %0d", i * 1000 + k, want);
          end
        end
        if (rel[i]) begin
          n_checks++;
          want = -1;
          if (exp_rel.size() > 0) want = exp_rel.pop_front();
          if (i * 1000 + k !== want) begin
            n_fail++;
            $display("FAIL long release: got id %0d want id %0d", i * 1000 + k, want);
          end
        end
      end
      if (k == 26 || k == 27 || k == 76 || k == 77) begin
        n_checks++;
        if (lng[2] !== (k == 27 || k == 76)) begin
          n_fail++;
          $display("FAIL long flag@%0d: got %b want %b", k, lng[2], (k == 27 || k == 76));
        end
      end
      if (k == 70) raw[2] = 1'b0;
    end
    n_checks++;
    if (exp_press.size() + exp_rel.size() != 0) begin
      n_fail++;
      $display("FAIL long missing: %0d press %0d release pulses not seen",
               exp_press.size(), exp_rel.size());
    end
  endtask

  // Two-cycle drop while held: no release, and the repeat timer restarts at edge 34.
  task automatic test_held_bounce();
    int want;
    exp_press = {3007, 3027, 3042, 3050};
    exp_rel   = {3062};
    @(posedge clk); #1;
    raw[3] = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
        if (press[i]) begin
          n_checks++;
          want = -1;
          if (exp_press.size() > 0) want = exp_press.pop_front();
          if (i * 1000 + k !== want) begin
            n_fail++;
            $display("FAIL bounce press: got id %0d want id %0d", i * 1000 + k, want);
          end
        end
        if (rel[i]) begin
          n_checks++;
          want = -1;
          if (exp_rel.size() > 0) want = exp_rel.pop_front();
          if (i * 1000 + k !== want) begin
            n_fail++;
            $display("FAIL bounce release: got id %0d want id %0d", i * 1000 + k, want);
          end
        end
      end
      if (k == 33 || k == 40) begin
        n_checks++;
        if ({level[3], lng[3]} !== 2'b11) begin
          n_fail++;
          $display("FAIL bounce level/long@%0d: got %b%b want 11", k, level[3], lng[3]);
        end
      end
      if (k == 29) raw[3] = 1'b0;
      if (k == 31) raw[3] = 1'b1;
      if (k == 55) raw[3] = 1'b0;
    end
    n_checks++;
    if (exp_press.size() + exp_rel.size() != 0) begin
      n_fail++;
      $display("FAIL bounce missing: %0d press %0d release pulses not seen",
               exp_press.size(), exp_rel.size());
    end
  endtask

  task automatic test_async_reset();
    int want;
    exp_press = {2007, 2027};
    exp_rel   = {};
    @(posedge clk); #1;
    raw[2] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
        if (press[i]) begin
          n_checks++;
          want = -1;
          if (exp_press.size() > 0) want = exp_press.pop_front();
          if (i * 1000 + k !== want) begin
            n_fail++;
            $display("FAIL areset press: got id %0d want id %0d", i * 1000 + k, want);
          end
        end
      end
    end
    n_checks++;
    if (lng[2] !== 1'b1) begin n_fail++; $display("FAIL areset held: got %b want 1", lng[2]); end
    #2;
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if ({level, lng, press, rel} !== 20'b0) begin
      n_fail++;
      $display("FAIL areset clear: got lvl %b long %b press %b rel %b want all 0",
               level, lng, press, rel);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_ni    = 1'b1;
    exp_press = {2007};
    exp_rel   = {2017};
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
        if (press[i]) begin
          n_checks++;
          want = -1;
          if (exp_press.size() > 0) want = exp_press.pop_front();
          if (i * 1000 + k !== want) begin
            n_fail++;
            $display("FAIL areset restart press: got id %0d want id %0d", i * 1000 + k, want);
          end
        end
        if (rel[i]) begin
          n_checks++;
          want = -1;
          if (exp_rel.size() > 0) want = exp_rel.pop_front();
          if (i * 1000 + k !== want) begin
            n_fail++;
            $display("FAIL areset restart release: got id %0d want id %0d", i * 1000 + k, want);
          end
        end
      end
      if (k == 10) raw[2] = 1'b0;
    end
    n_checks++;
    if (exp_press.size() + exp_rel.size() != 0) begin
      n_fail++;
      $display("FAIL areset missing: %0d press %0d release pulses not seen",
               exp_press.size(), exp_rel.size());
    end
  endtask

  task automatic test_independence();
    int want;
    logic [4:0] others;
    exp_press = {7, 4009};
    exp_rel   = {19, 4021};
    others    = 5'b0;
    @(posedge clk); #1;
    raw[0] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      others = others | ((level | press | rel | lng) & 5'b01110);
      for (int i = 0; i < 5; i++) begin
        if (press[i]) begin
          n_checks++;
          want = -1;
          if (exp_press.size() > 0) want = exp_press.pop_front();
          if (i * 1000 + k !== want) begin
            n_fail++;
            $display("FAIL indep press: got id %0d want id %0d", i * 1000 + k, want);
          end
        end
        if (rel[i]) begin
          n_checks++;
          want = -1;
          if (exp_rel.size() > 0) want = exp_rel.pop_front();
          if (i * 1000 + k !== want) begin
            n_fail++;
            $display("FAIL indep release: got id %0d want id %0d", i * 1000 + k, want);
          end
        end
      end
      if (k == 2) raw[4] = 1'b1;
      if (k == 12) raw[0] = 1'b0;
      if (k == 14) raw[4] = 1'b0;
    end
    n_checks++;
    if (others !== 5'b0) begin
      n_fail++;
      $display("FAIL indep crosstalk: got %b want 00000", others);
    end
    n_checks++;
    if (exp_press.size() + exp_rel.size() != 0) begin
      n_fail++;
      $display("FAIL indep missing: %0d press %0d release pulses not seen",
               exp_press.size(), exp_rel.size());
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_long_repeat();
    test_held_bounce();
    test_async_reset();
    test_independence();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
